// File: rtl/sort4_group_collector.sv
// Collects serial sorted elements into GROUP-wide words framed by in_last; reports max/ordering.
// Group presented the cycle after its last element is accepted; zero-bubble when out_ready=1.
module sort4_group_collector #(
  parameter int DW    = 3,
  parameter int GROUP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GROUP*DW-1:0] out_data,
  output logic [DW-1:0]       out_max,
  output logic                out_sorted,
  output logic                out_frame_err,
  output logic [7:0]          short_drop_cnt
);

  localparam int IW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(GROUP - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [GROUP*DW-1:0] bank;
  logic [DW-1:0]       run_max;
  logic [DW-1:0]       prev;
  logic                run_sorted;

  logic                accept;
  logic [GROUP*DW-1:0] bank_nxt;
  logic [DW-1:0]       max_nxt;
  logic                sorted_nxt;

  assign in_ready  = (state == FILL) | out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // Slot 0 restarts the running statistics; a HOLD-state accept always lands here.
  always_comb begin
    bank_nxt = bank;
    bank_nxt[int'(idx)*DW +: DW] = in_data;
    if (idx == '0) begin
      max_nxt    = in_data;
      sorted_nxt = 1'b1;
    end else begin
      max_nxt    = (in_data > run_max) ? in_data : run_max;
      sorted_nxt = run_sorted & (in_data >= prev);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= FILL;
      idx            <= '0;
      bank           <= '0;
      run_max        <= '0;
      prev           <= '0;
      run_sorted     <= 1'b0;
      out_data       <= '0;
      out_max        <= '0;
      out_sorted     <= 1'b0;
      out_frame_err  <= 1'b0;
      short_drop_cnt <= '0;
    end else begin
      if (state == HOLD && out_ready)
        state <= FILL;

      if (accept) begin
        bank       <= bank_nxt;
        run_max    <= max_nxt;
        run_sorted <= sorted_nxt;
        prev       <= in_data;
        if (idx == LAST_IDX) begin
          // Output registers are a separate bank so refilling never disturbs the held group.
          out_data      <= bank_nxt;
          out_max       <= max_nxt;
          out_sorted    <= sorted_nxt;
          out_frame_err <= ~in_last;
          idx           <= '0;
          state         <= HOLD;
        end else if (in_last) begin
          idx <= '0;
          if (short_drop_cnt != 8'hFF)
            short_drop_cnt <= short_drop_cnt + 8'd1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort4_group_collector.sv
// Directed bench for sort4_group_collector (DW=3, GROUP=4) with hand-computed expectations.
module tb_sort4_group_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [2:0]  out_max;
  logic        out_sorted;
  logic        out_frame_err;
  logic [7:0]  short_drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sort4_group_collector #(.DW(3), .GROUP(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_max        (out_max),
    .out_sorted     (out_sorted),
    .out_frame_err  (out_frame_err),
    .short_drop_cnt (short_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_group(input string tag, input logic [11:0] d, input logic [2:0] m,
                           input logic s, input logic e);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".max"}, out_max, m);
    chk({tag, ".sorted"}, out_sorted, s);
    chk({tag, ".frame_err"}, out_frame_err, e);
  endtask

  initial begin
    // 1: reset with in_valid held high
    rst_n = 1'b0; in_valid = 1'b1; in_data = 3'd5; in_last = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_ready", in_ready, 1);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.out_data", out_data, 0);
      chk("rst.out_max", out_max, 0);
      chk("rst.out_sorted", out_sorted, 0);
      chk("rst.frame_err", out_frame_err, 0);
      chk("rst.drop_cnt", short_drop_cnt, 0);
    end
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    tick();

    // 2: 1,3,3,6 with consumer ready
    out_ready = 1'b1;
    send(3'd1, 1'b0); send(3'd3, 1'b0); send(3'd3, 1'b0);
    chk("t2.no_early_valid", out_valid, 0);
    send(3'd6, 1'b1);
    chk_group("t2", 12'o6331, 3'd6, 1'b1, 1'b0);
    tick();
    chk("t2.valid_drop", out_valid, 0);

    // 3: 5,2,7,0 held for 3 cycles; offered data during hold must be ignored
    out_ready = 1'b0;
    send(3'd5, 1'b0); send(3'd2, 1'b0); send(3'd7, 1'b0); send(3'd0, 1'b1);
    chk_group("t3", 12'o0725, 3'd7, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 3'd3; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3.hold_in_ready", in_ready, 0);
      tick();
      chk("t3.hold_valid", out_valid, 1);
      chk("t3.hold_data", out_data, 12'o0725);
      chk("t3.hold_max", out_max, 3'd7);
    end
    in_valid = 1'b0;
    chk("t3.hold_drop_cnt", short_drop_cnt, 0);
    out_ready = 1'b1;
    tick();
    chk("t3.release", out_valid, 0);

    // 4: short frame 4,4 then an intact group
    send(3'd4, 1'b0); send(3'd4, 1'b1);
    chk("t4.drop_cnt", short_drop_cnt, 1);
    chk("t4.no_valid", out_valid, 0);
    send(3'd0, 1'b0); send(3'd1, 1'b0); send(3'd2, 1'b0); send(3'd3, 1'b1);
    chk_group("t4", 12'o3210, 3'd3, 1'b1, 1'b0);
    tick();
    chk("t4.valid_drop", out_valid, 0);

    // 5: back-to-back descending stream, 8 elements, no stalls
    for (int i = 0; i < 8; i++) begin
      chk("t5.in_ready", in_ready, 1);
      send(3'(7 - i), (i % 4) == 3);
      if (i == 3) chk_group("t5a", 12'o4567, 3'd7, 1'b0, 1'b0);
      else if (i == 7) chk_group("t5b", 12'o0123, 3'd3, 1'b0, 1'b0);
      else chk("t5.gap_valid", out_valid, 0);
    end
    tick();
    chk("t5.valid_drop", out_valid, 0);

    // 6: partial group discarded by reset
    send(3'd1, 1'b0); send(3'd2, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6.drop_cnt_cleared", short_drop_cnt, 0);
    send(3'd6, 1'b0); send(3'd5, 1'b0); send(3'd4, 1'b0);
    chk("t6.no_early_valid", out_valid, 0);
    send(3'd3, 1'b1);
    chk_group("t6", 12'o3456, 3'd6, 1'b0, 1'b0);
    tick();

    // 7: long frame, no in_last
    send(3'd2, 1'b0); send(3'd2, 1'b0); send(3'd5, 1'b0); send(3'd7, 1'b0);
    chk_group("t7", 12'o7522, 3'd7, 1'b1, 1'b1);
    tick();
    chk("t7.valid_drop", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
